// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding
// and default widths used by mem_port_arbiter and mem_arb_wdog.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IFETCH  = 2'd1,
    ST_DACCESS = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 15;

endpackage

// File: rtl/mem_port_arbiter_wdog.sv
// Wait-cycle watchdog for the memory port arbiter. Counts consecutive
// busy cycles without an acknowledge and pulses o_expire on the
// MAX_WAIT-th such cycle. Only instantiated when MEM_ARB_TIMEOUT_EN is
// defined.
module mem_arb_wdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_expire;

  assign w_expire = i_busy & ~i_ack & (r_cnt == CW'(MAX_WAIT - 1));
  assign o_expire = w_expire;

  // Count unacknowledged busy cycles; restart on ack, idle or expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_busy || i_ack || w_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the M-stage
// load/store unit. Data accesses win over fetches, grants are never
// preempted, and the request address/we/wdata are captured at grant so
// the memory side sees stable values for the whole access.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a wait watchdog and
// the sticky ErrTimeout output.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              IReqF,
  input  logic [ADDR_W-1:0] IAddrF,
  output logic [DATA_W-1:0] IRdataF,
  output logic              IValidF,
  // data side
  input  logic              DReqM,
  input  logic              DWeM,
  input  logic [ADDR_W-1:0] DAddrM,
  input  logic [DATA_W-1:0] DWdataM,
  output logic [DATA_W-1:0] DRdataM,
  output logic              DValidM,
  // memory side
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRdata,
  // pipeline control
  input  logic              RedirectE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushW
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              ErrTimeout
`endif
);

  arb_state_t        r_state;
  logic              r_memReq;
  logic              r_discard;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic w_ackI;
  logic w_ackD;
  logic w_timeout;
  logic w_dstall;
  logic w_istall;

`ifdef MEM_ARB_TIMEOUT_EN
  logic r_errTimeout;

  mem_arb_wdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_busy   (r_memReq),
    .i_ack    (MemAck),
    .o_expire (w_timeout)
  );

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_errTimeout <= 1'b0;
    end else if (w_timeout) begin
      r_errTimeout <= 1'b1;
    end
  end

  assign ErrTimeout = r_errTimeout;
`else
  assign w_timeout = 1'b0;
`endif

  // An ack only counts while an access is outstanding; in IDLE it is ignored.
  assign w_ackI = (r_state == ST_IFETCH)  & MemAck;
  assign w_ackD = (r_state == ST_DACCESS) & MemAck;

  assign IValidF = w_ackI & ~r_discard;
  assign DValidM = w_ackD;
  assign IRdataF = MemRdata;
  assign DRdataM = MemRdata;

  assign MemReq   = r_memReq;
  assign MemWe    = r_we;
  assign MemAddr  = r_addr;
  assign MemWdata = r_wdata;

  // A pending data access freezes the whole front of the pipe and bubbles W;
  // a pending fetch alone only holds F and bubbles D.
  assign w_dstall = DReqM & ~DValidM;
  assign w_istall = IReqF & ~IValidF;
  assign StallF   = w_dstall | w_istall;
  assign StallD   = w_dstall;
  assign StallE   = w_dstall;
  assign StallM   = w_dstall;
  assign FlushW   = w_dstall;
  assign FlushD   = ~w_dstall & w_istall;

  // Arbitration FSM: grant from IDLE, capture the request, hold until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_memReq  <= 1'b0;
      r_discard <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (DReqM) begin
            r_state   <= ST_DACCESS;
            r_memReq  <= 1'b1;
            r_discard <= 1'b0;
            r_we      <= DWeM;
            r_addr    <= DAddrM;
            r_wdata   <= DWdataM;
          end else if (IReqF) begin
            r_state   <= ST_IFETCH;
            r_memReq  <= 1'b1;
            r_discard <= RedirectE;
            r_we      <= 1'b0;
            r_addr    <= IAddrF;
            r_wdata   <= '0;
          end
        end
        ST_IFETCH: begin
          if (MemAck || w_timeout) begin
            r_state   <= ST_IDLE;
            r_memReq  <= 1'b0;
            r_discard <= 1'b0;
          end else if (RedirectE) begin
            r_discard <= 1'b1;
          end
        end
        ST_DACCESS: begin
          if (MemAck || w_timeout) begin
            r_state  <= ST_IDLE;
            r_memReq <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_memReq  <= 1'b0;
          r_discard <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
// Define MEM_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              IReqF;
  logic [ADDR_W-1:0] IAddrF;
  logic [DATA_W-1:0] IRdataF;
  logic              IValidF;
  logic              DReqM;
  logic              DWeM;
  logic [ADDR_W-1:0] DAddrM;
  logic [DATA_W-1:0] DWdataM;
  logic [DATA_W-1:0] DRdataM;
  logic              DValidM;
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic              MemAck;
  logic [DATA_W-1:0] MemRdata;
  logic              RedirectE;
  logic              StallF, StallD, StallE, StallM, FlushD, FlushW;
`ifdef MEM_ARB_TIMEOUT_EN
  logic              ErrTimeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .IReqF     (IReqF),
    .IAddrF    (IAddrF),
    .IRdataF   (IRdataF),
    .IValidF   (IValidF),
    .DReqM     (DReqM),
    .DWeM      (DWeM),
    .DAddrM    (DAddrM),
    .DWdataM   (DWdataM),
    .DRdataM   (DRdataM),
    .DValidM   (DValidM),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWdata  (MemWdata),
    .MemAck    (MemAck),
    .MemRdata  (MemRdata),
    .RedirectE (RedirectE),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushW    (FlushW)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .ErrTimeout(ErrTimeout)
`endif
  );

  task advance;
    @(posedge clk);
    #1;
  endtask

  task settle;
    @(negedge clk);
  endtask

  task idleInputs;
    IReqF = 0; IAddrF = '0; DReqM = 0; DWeM = 0; DAddrM = '0; DWdataM = '0;
    MemAck = 0; MemRdata = '0; RedirectE = 0;
  endtask

  task test_reset;
    rst = 1; idleInputs();
    IReqF = 1;
    settle();
    checks++; if (StallF !== 1'b1) begin errors++; $display("[TB] FAIL reset_stallf_follows: got %b expected 1", StallF); end
    checks++; if (FlushD !== 1'b1) begin errors++; $display("[TB] FAIL reset_flushd_follows: got %b expected 1", FlushD); end
    advance(); advance();
    rst = 0; IReqF = 0;
    settle();
    checks++; if (MemReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_memreq: got %b expected 0", MemReq); end
    checks++; if (IValidF !== 1'b0) begin errors++; $display("[TB] FAIL reset_ivalid: got %b expected 0", IValidF); end
    checks++; if (DValidM !== 1'b0) begin errors++; $display("[TB] FAIL reset_dvalid: got %b expected 0", DValidM); end
    checks++; if (MemAddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_memaddr: got %h expected 0", MemAddr); end
    checks++; if (MemWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_memwe: got %b expected 0", MemWe); end
    checks++; if (MemWdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_memwdata: got %h expected 0", MemWdata); end
    checks++; if ({StallF, StallM, FlushD, FlushW} !== 4'b0) begin errors++; $display("[TB] FAIL reset_stalls: got %b expected 0000", {StallF, StallM, FlushD, FlushW}); end
`ifdef MEM_ARB_TIMEOUT_EN
    checks++; if (ErrTimeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_errtimeout: got %b expected 0", ErrTimeout); end
`endif
    advance();
  endtask

  task test_fetch;
    IReqF = 1; IAddrF = 32'h40;
    settle();
    checks++; if ({MemReq, StallF, FlushD} !== 3'b011) begin errors++; $display("[TB] FAIL fetch_idle: got memreq/stallf/flushd %b expected 011", {MemReq, StallF, FlushD}); end
    advance();
    settle();
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h40 || MemWe !== 1'b0) begin errors++; $display("[TB] FAIL fetch_mem: got req %b addr %h we %b expected 1 40 0", MemReq, MemAddr, MemWe); end
    checks++; if ({IValidF, StallF, FlushD} !== 3'b011) begin errors++; $display("[TB] FAIL fetch_wait: got ivalid/stallf/flushd %b expected 011", {IValidF, StallF, FlushD}); end
    advance();
    MemAck = 1; MemRdata = 32'h00500093;
    settle();
    checks++; if (IValidF !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ivalid: got %b expected 1", IValidF); end
    checks++; if (IRdataF !== 32'h00500093) begin errors++; $display("[TB] FAIL fetch_irdata: got %h expected 00500093", IRdataF); end
    checks++; if ({StallF, FlushD} !== 2'b00) begin errors++; $display("[TB] FAIL fetch_ack_stall: got %b expected 00", {StallF, FlushD}); end
    advance();
    IReqF = 0; MemAck = 0;
    settle();
    checks++; if (MemReq !== 1'b0 || IValidF !== 1'b0) begin errors++; $display("[TB] FAIL fetch_done: got req %b ivalid %b expected 0 0", MemReq, IValidF); end
    advance();
  endtask

  task test_load_priority;
    IReqF = 1; IAddrF = 32'h40; DReqM = 1; DWeM = 0; DAddrM = 32'h100;
    settle();
    checks++; if ({StallF, StallD, StallE, StallM, FlushW, FlushD} !== 6'b111110) begin errors++; $display("[TB] FAIL prio_idle_stalls: got %b expected 111110", {StallF, StallD, StallE, StallM, FlushW, FlushD}); end
    advance();
    settle();
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h100 || MemWe !== 1'b0) begin errors++; $display("[TB] FAIL prio_grant: got req %b addr %h we %b expected 1 100 0", MemReq, MemAddr, MemWe); end
    checks++; if (DValidM !== 1'b0 || StallM !== 1'b1 || FlushW !== 1'b1) begin errors++; $display("[TB] FAIL prio_wait: got dvalid %b stallm %b flushw %b expected 0 1 1", DValidM, StallM, FlushW); end
    advance();
    MemAck = 1; MemRdata = 32'h12345678;
    settle();
    checks++; if (DValidM !== 1'b1 || DRdataM !== 32'h12345678) begin errors++; $display("[TB] FAIL prio_dvalid: got %b %h expected 1 12345678", DValidM, DRdataM); end
    checks++; if ({StallF, StallM, FlushW, FlushD} !== 4'b1001) begin errors++; $display("[TB] FAIL prio_ack_stalls: got %b expected 1001", {StallF, StallM, FlushW, FlushD}); end
    advance();
    DReqM = 0; MemAck = 0;
    settle();
    checks++; if (MemReq !== 1'b0) begin errors++; $display("[TB] FAIL prio_gap: got memreq %b expected 0", MemReq); end
    advance();
    settle();
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h40 || MemWe !== 1'b0) begin errors++; $display("[TB] FAIL prio_then_fetch: got req %b addr %h we %b expected 1 40 0", MemReq, MemAddr, MemWe); end
    advance();
    MemAck = 1; MemRdata = 32'h00000013;
    settle();
    checks++; if (IValidF !== 1'b1 || IRdataF !== 32'h00000013) begin errors++; $display("[TB] FAIL prio_ivalid: got %b %h expected 1 00000013", IValidF, IRdataF); end
    advance();
    idleInputs();
    advance();
  endtask

  task test_store_during_fetch;
    IReqF = 1; IAddrF = 32'h48;
    advance();
    DReqM = 1; DWeM = 1; DAddrM = 32'h200; DWdataM = 32'hDEADBEEF;
    settle();
    checks++; if (MemAddr !== 32'h48 || MemWe !== 1'b0) begin errors++; $display("[TB] FAIL store_fetch_kept: got addr %h we %b expected 48 0", MemAddr, MemWe); end
    checks++; if ({StallF, StallD, StallE, StallM, FlushW, FlushD} !== 6'b111110) begin errors++; $display("[TB] FAIL store_mid_stalls: got %b expected 111110", {StallF, StallD, StallE, StallM, FlushW, FlushD}); end
    advance();
    MemAck = 1; MemRdata = 32'hCAFE0001;
    settle();
    checks++; if (IValidF !== 1'b1 || StallM !== 1'b1 || StallF !== 1'b1) begin errors++; $display("[TB] FAIL store_fetch_ack: got ivalid %b stallm %b stallf %b expected 1 1 1", IValidF, StallM, StallF); end
    advance();
    IReqF = 0; MemAck = 0;
    settle();
    checks++; if (MemReq !== 1'b0 || StallD !== 1'b1) begin errors++; $display("[TB] FAIL store_gap: got req %b stalld %b expected 0 1", MemReq, StallD); end
    advance();
    settle();
    checks++; if (MemReq !== 1'b1 || MemWe !== 1'b1 || MemWdata !== 32'hDEADBEEF || MemAddr !== 32'h200) begin errors++; $display("[TB] FAIL store_grant: got req %b we %b wdata %h addr %h expected 1 1 deadbeef 200", MemReq, MemWe, MemWdata, MemAddr); end
    advance();
    MemAck = 1;
    settle();
    checks++; if (DValidM !== 1'b1 || StallM !== 1'b0) begin errors++; $display("[TB] FAIL store_done: got dvalid %b stallm %b expected 1 0", DValidM, StallM); end
    advance();
    idleInputs();
    advance();
  endtask

  task test_redirect;
    IReqF = 1; IAddrF = 32'h44;
    advance();
    RedirectE = 1;
    settle();
    checks++; if (MemAddr !== 32'h44) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 44", MemAddr); end
    advance();
    RedirectE = 0; IAddrF = 32'h80; MemAck = 1; MemRdata = 32'hBAD0BAD0;
    settle();
    checks++; if (IValidF !== 1'b0 || StallF !== 1'b1) begin errors++; $display("[TB] FAIL redir_drop: got ivalid %b stallf %b expected 0 1", IValidF, StallF); end
    advance();
    MemAck = 0;
    settle();
    checks++; if (MemReq !== 1'b0) begin errors++; $display("[TB] FAIL redir_idle: got memreq %b expected 0", MemReq); end
    advance();
    settle();
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h80) begin errors++; $display("[TB] FAIL redir_newaddr: got req %b addr %h expected 1 80", MemReq, MemAddr); end
    advance();
    MemAck = 1; MemRdata = 32'h00A00113;
    settle();
    checks++; if (IValidF !== 1'b1 || IRdataF !== 32'h00A00113) begin errors++; $display("[TB] FAIL redir_refetch: got %b %h expected 1 00a00113", IValidF, IRdataF); end
    advance();
    idleInputs();
    advance();
  endtask

  task test_reset_mid_access;
    DReqM = 1; DWeM = 1; DAddrM = 32'h300; DWdataM = 32'h55;
    advance();
    settle();
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h300) begin errors++; $display("[TB] FAIL rstmid_grant: got req %b addr %h expected 1 300", MemReq, MemAddr); end
    advance();
    rst = 1; DReqM = 0;
    advance();
    rst = 0; MemAck = 1; MemRdata = 32'h77;
    settle();
    checks++; if (MemReq !== 1'b0 || DValidM !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_abandon: got req %b dvalid %b expected 0 0", MemReq, DValidM); end
    checks++; if (MemAddr !== 32'h0 || MemWe !== 1'b0 || MemWdata !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_cleared: got addr %h we %b wdata %h expected 0 0 0", MemAddr, MemWe, MemWdata); end
    advance();
    MemAck = 0;
    settle();
    checks++; if (MemReq !== 1'b0 || DValidM !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_lateack: got req %b dvalid %b expected 0 0", MemReq, DValidM); end
    advance();
  endtask

  task test_random;
    bit        mBusy, mData, mWe, mDiscard, mErr;
    bit [31:0] mAddr, mWdata;
    int        mWait;
    bit        eDValid, eIValid, eExpire, eDstall, eIstall;
    bit        lastD, lastI;
    int        shown;
    rst = 1; idleInputs();
    advance();
    rst = 0;
    mBusy = 0; mData = 0; mWe = 0; mDiscard = 0; mErr = 0;
    mAddr = 0; mWdata = 0; mWait = 0; lastD = 0; lastI = 0; shown = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (DReqM && lastD) DReqM = 0;
      else if (!DReqM && ($urandom % 4 == 0)) begin
        DReqM = 1; DWeM = 1'($urandom % 2); DAddrM = $urandom; DWdataM = $urandom;
      end
      if (IReqF && lastI) IReqF = 0;
      else if (!IReqF && ($urandom % 3 == 0)) begin
        IReqF = 1; IAddrF = $urandom;
      end
      MemAck   = ($urandom % 10) < 3;
      MemRdata = $urandom;
      RedirectE = ($urandom % 8 == 0) && !(mBusy && !mData && MemAck);
      if (RedirectE) IAddrF = $urandom;

      eDValid = mBusy && mData && MemAck;
      eIValid = mBusy && !mData && MemAck && !mDiscard;
`ifdef MEM_ARB_TIMEOUT_EN
      eExpire = mBusy && !MemAck && (mWait + 1 == MAX_WAIT);
`else
      eExpire = 0;
`endif
      eDstall = DReqM && !eDValid;
      eIstall = IReqF && !eIValid;

      settle();
      checks++;
      if (MemReq !== mBusy || DValidM !== eDValid || IValidF !== eIValid) begin
        errors++;
        if (shown++ < 20) $display("[TB] FAIL rand_handshake cyc %0d: got req/dv/iv %b%b%b expected %b%b%b", cyc, MemReq, DValidM, IValidF, mBusy, eDValid, eIValid);
      end
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushW} !== {eDstall | eIstall, eDstall, eDstall, eDstall, !eDstall && eIstall, eDstall}) begin
        errors++;
        if (shown++ < 20) $display("[TB] FAIL rand_stalls cyc %0d: got %b expected %b", cyc, {StallF, StallD, StallE, StallM, FlushD, FlushW}, {eDstall | eIstall, eDstall, eDstall, eDstall, !eDstall && eIstall, eDstall});
      end
      if (mBusy) begin
        checks++;
        if (MemAddr !== mAddr || MemWe !== mWe || (mWe && MemWdata !== mWdata)) begin
          errors++;
          if (shown++ < 20) $display("[TB] FAIL rand_memside cyc %0d: got addr %h we %b wdata %h expected %h %b %h", cyc, MemAddr, MemWe, MemWdata, mAddr, mWe, mWdata);
        end
      end
      if (eDValid) begin
        checks++;
        if (DRdataM !== MemRdata) begin errors++; if (shown++ < 20) $display("[TB] FAIL rand_drdata cyc %0d: got %h expected %h", cyc, DRdataM, MemRdata); end
      end
      if (eIValid) begin
        checks++;
        if (IRdataF !== MemRdata) begin errors++; if (shown++ < 20) $display("[TB] FAIL rand_irdata cyc %0d: got %h expected %h", cyc, IRdataF, MemRdata); end
      end
`ifdef MEM_ARB_TIMEOUT_EN
      checks++;
      if (ErrTimeout !== mErr) begin errors++; if (shown++ < 20) $display("[TB] FAIL rand_errtimeout cyc %0d: got %b expected %b", cyc, ErrTimeout, mErr); end
`endif

      // model update: one outstanding access at a time, data wins at grant
      if (!mBusy) begin
        if (DReqM) begin
          mBusy = 1; mData = 1; mAddr = DAddrM; mWe = DWeM; mWdata = DWdataM; mDiscard = 0; mWait = 0;
        end else if (IReqF) begin
          mBusy = 1; mData = 0; mAddr = IAddrF; mWe = 0; mDiscard = RedirectE; mWait = 0;
        end
      end else if (MemAck || eExpire) begin
        mBusy = 0; mDiscard = 0; mWait = 0;
        if (eExpire) mErr = 1;
      end else begin
        mWait++;
        if (!mData && RedirectE) mDiscard = 1;
      end
      lastD = eDValid;
      lastI = eIValid;
      advance();
    end
    idleInputs();
    advance();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task test_timeout;
    rst = 1; idleInputs();
    advance();
    rst = 0; IReqF = 1; IAddrF = 32'h60;
    advance();
    IReqF = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      settle();
      checks++;
      if (MemReq !== 1'b1 || ErrTimeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_wait %0d: got req %b err %b expected 1 0", i, MemReq, ErrTimeout); end
      advance();
    end
    settle();
    checks++; if (MemReq !== 1'b0 || ErrTimeout !== 1'b1 || IValidF !== 1'b0) begin errors++; $display("[TB] FAIL timeout_fire: got req %b err %b ivalid %b expected 0 1 0", MemReq, ErrTimeout, IValidF); end
    for (int i = 0; i < 5; i++) advance();
    settle();
    checks++; if (ErrTimeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", ErrTimeout); end
    advance();
    rst = 1;
    advance();
    rst = 0;
    settle();
    checks++; if (ErrTimeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: got %b expected 0", ErrTimeout); end
    advance();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_load_priority();
    test_store_during_fetch();
    test_redirect();
    test_reset_mid_access();
    test_random();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
